register_file: RTL and testbench
================================

# register_file

Parametrised multi-port register file built from per-entry enabled registers. It provides one write port with byte enables, two combinational read ports, optional write-to-read bypass, and a hardwired zero entry. It is the storage block for datapath registers and replaces single 32-bit enabled-register instances wherever more than one register is indexed by address.

## Interface
Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8
- NUM_REGS, 32, number of entries; 2..1024, need not be a power of two
- ADDR_W, $clog2(NUM_REGS), address width; derived, never overridden
- RESET_VALUE, 0, WIDTH-bit value loaded into every entry on reset or clear
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a read of the entry being written this cycle returns the merged new value

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; loads RESET_VALUE into all entries
- clear  in  1  synchronous clear of all entries to RESET_VALUE
- wr_enable  in  1  write strobe
- wr_addr  in  ADDR_W  write entry index
- wr_data  in  WIDTH  write data
- wr_byte_en  in  WIDTH/8  per-byte write mask; bit i covers bits [8i+7:8i]
- rd_addr_a  in  ADDR_W  read port A index
- rd_data_a  out  WIDTH  read port A data
- rd_addr_b  in  ADDR_W  read port B index
- rd_data_b  out  WIDTH  read port B data

## Operation
- Each entry holds WIDTH bits. Byte i of entry wr_addr is updated on the clock edge when wr_enable is 1 and wr_byte_en[i] is 1. All other bytes hold their value.
- Priority per edge: reset (asynchronous) > clear > write.
- clear = 1 with wr_enable = 1: the write is dropped and all entries become RESET_VALUE.
- ZERO_REG = 1:
  - Entry 0 is not stored.
  - Reads of address 0 return 0, regardless of RESET_VALUE.
  - Writes to address 0 are ignored.
  - Bypass never applies to address 0.
- Out-of-range address (>= NUM_REGS):
  - Writes are ignored.
  - Reads return 0.
  - Bypass does not apply.
- Reads are combinational from the stored array.
- BYPASS = 1: when wr_enable = 1, clear = 0, the addresses match, and the address is valid and writable, read data equals a byte-wise merge. Bytes with wr_byte_en set take wr_data; all other bytes take the stored data.
- BYPASS = 0: reads return the pre-edge stored value.
- Both read ports are independent. They may read the same address as each other and as the write port in the same cycle.
- wr_byte_en = 0 with wr_enable = 1 is a no-op and produces no bypass change.

## Timing
- Write latency is one edge. Data is visible on a non-bypassed read immediately after the rising edge following the write cycle.
- Bypass latency is zero: the value is visible combinationally in the write cycle.
- Reset:
  - All entries become RESET_VALUE immediately on reset assertion, without a clock.
  - Both rd_data outputs reflect this combinationally; address 0 still reads 0 when ZERO_REG = 1.
  - Deassertion takes effect at the next edge.
- Reset asserted mid-write: the write is lost, and the entry reads RESET_VALUE after reset.
- Bypass is suppressed while reset or clear is asserted.
- There are no stalls, handshakes or multi-cycle states. Every edge accepts one write.

## Structure
- Sub-module `enabled_register`:
  - Parameters WIDTH and RESET_VALUE; ports clk, reset, clear, enable, d, q.
  - Instantiated once per byte lane per entry.
  - Asynchronous active-high reset.
- A generate loop over entries and byte lanes.
- Two read muxes, each with optional bypass merge logic.
- Shared package `regfile_pkg` contains:
  - default WIDTH and NUM_REGS constants
  - the byte-lane width constant (8)
  - a function computing the byte-merged value from old data, new data and the mask

## Test plan
- Assert reset, then release; read addresses 1 and NUM_REGS-1 -> both read RESET_VALUE. Set RESET_VALUE=32'hDEAD_BEEF in a second configuration -> 32'hDEADBEEF, while address 0 reads 0.
- Write 88 to address 5 with byte_en 4'hF, then wr_enable=0 with wr_data=89 -> address 5 reads 88 in the following cycles.
- Write 32'h1122_3344 to address 7, then 32'hAABB_CCDD with byte_en 4'b0101 -> address 7 reads 32'h11BB_33DD.
- BYPASS=1: write 32'h0000_00FF to address 3 while rd_addr_a=3 -> rd_data_a=32'hFF in the same cycle. BYPASS=0 -> old value until the edge.
- Write 55 to address 0 and to address NUM_REGS (NUM_REGS=20) -> both read 0; no other entry changes.
- Write 77 to address 9, then assert clear together with a write of 66 to address 9 -> address 9 reads RESET_VALUE. Pulse reset between edges after writing 12 to address 2 -> rd_data reads RESET_VALUE before the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file.
//   DEFAULT_WIDTH / DEFAULT_NUM_REGS : default geometry
//   BYTE_W                           : byte-lane width
//   byte_merge()                     : byte-wise merge of old/new data under a lane mask
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam int unsigned DEFAULT_NUM_REGS = 32;
    localparam int unsigned BYTE_W           = 8;

    // Widest data path byte_merge supports; callers zero-extend and truncate.
    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned MAX_LANES = MAX_WIDTH / BYTE_W;

    // Lanes with mask set take new_data, all other lanes keep old_data.
    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0] old_data,
        input logic [MAX_WIDTH-1:0] new_data,
        input logic [MAX_LANES-1:0] mask
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_data;
        for (int i = 0; i < int'(MAX_LANES); i++) begin
            if (mask[i]) begin
                merged[i*BYTE_W +: BYTE_W] = new_data[i*BYTE_W +: BYTE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/register_file_enabled_register.sv
// Enabled register with asynchronous reset and synchronous clear.
//   clk, reset (async, active-high), clear (sync), enable, d -> q
// Priority: reset > clear > enable.
module enabled_register #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (clear) begin
            q <= RESET_VALUE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Multi-port register file: one byte-masked write port, two combinational
// read ports, optional write-to-read bypass and optional hardwired zero entry.
//   clk, reset (async, active-high), clear (sync)
//   wr_enable, wr_addr, wr_data, wr_byte_en : write port
//   rd_addr_a -> rd_data_a, rd_addr_b -> rd_data_b : combinational read ports
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned      NUM_REGS    = DEFAULT_NUM_REGS,
    parameter int unsigned      ADDR_W      = $clog2(NUM_REGS),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               ZERO_REG    = 1'b1,
    parameter bit               BYPASS      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_enable,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH/8-1:0]    wr_byte_en,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [WIDTH-1:0]      rd_data_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [WIDTH-1:0]      rd_data_b
);

    localparam int unsigned LANES = WIDTH / BYTE_W;
    // Array spans the full address space so out-of-range reads hit a zero entry.
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: one enabled register per byte lane per stored entry.
    for (genvar e = 0; e < int'(DEPTH); e++) begin : g_entry
        if ((e >= int'(NUM_REGS)) || (ZERO_REG && (e == 0))) begin : g_const
            assign mem[e] = '0;
        end else begin : g_store
            logic             sel;
            logic [WIDTH-1:0] q_entry;

            assign sel    = wr_enable && (wr_addr == ADDR_W'(e));
            assign mem[e] = q_entry;

            for (genvar b = 0; b < int'(LANES); b++) begin : g_lane
                enabled_register #(
                    .WIDTH       (BYTE_W),
                    .RESET_VALUE (RESET_VALUE[b*BYTE_W +: BYTE_W])
                ) u_reg (
                    .clk    (clk),
                    .reset  (reset),
                    .clear  (clear),
                    .enable (sel && wr_byte_en[b]),
                    .d      (wr_data[b*BYTE_W +: BYTE_W]),
                    .q      (q_entry[b*BYTE_W +: BYTE_W])
                );
            end
        end
    end

    // Write target is a real, writable entry (bypass is only legal then).
    logic wr_ok;
    assign wr_ok = (32'(wr_addr) < NUM_REGS) && !(ZERO_REG && (wr_addr == '0));

    logic wr_live;
    assign wr_live = BYPASS && wr_enable && !clear && !reset && wr_ok;

    // Read port A with optional bypass merge.
    logic             byp_a;
    logic [WIDTH-1:0] merged_a;
    assign byp_a     = wr_live && (rd_addr_a == wr_addr);
    assign merged_a  = WIDTH'(byte_merge(MAX_WIDTH'(mem[rd_addr_a]), MAX_WIDTH'(wr_data),
                                         MAX_LANES'(wr_byte_en)));
    assign rd_data_a = byp_a ? merged_a : mem[rd_addr_a];

    // Read port B with optional bypass merge.
    logic             byp_b;
    logic [WIDTH-1:0] merged_b;
    assign byp_b     = wr_live && (rd_addr_b == wr_addr);
    assign merged_b  = WIDTH'(byte_merge(MAX_WIDTH'(mem[rd_addr_b]), MAX_WIDTH'(wr_data),
                                         MAX_LANES'(wr_byte_en)));
    assign rd_data_b = byp_b ? merged_b : mem[rd_addr_b];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. Two instances share all inputs:
//   dut0: NUM_REGS=20, RESET_VALUE=0,          BYPASS=1
//   dut1: NUM_REGS=20, RESET_VALUE=DEADBEEF,   BYPASS=0
module tb_register_file;

    localparam logic [31:0] RV1 = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        wr_enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] a0, b0, a1, b1;

    int vectors;
    int miscompares;

    register_file #(
        .WIDTH(32), .NUM_REGS(20), .RESET_VALUE(32'h0), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .wr_enable(wr_enable),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(a0), .rd_addr_b(rd_addr_b), .rd_data_b(b0)
    );

    register_file #(
        .WIDTH(32), .NUM_REGS(20), .RESET_VALUE(RV1), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .wr_enable(wr_enable),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_addr_a(rd_addr_a), .rd_data_a(a1), .rd_addr_b(rd_addr_b), .rd_data_b(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and samples happen off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
        wr_enable  = en;
        wr_addr    = addr;
        wr_data    = data;
        wr_byte_en = be;
    endtask

    task automatic test_reset();
        rd_addr_a = 5'd1;
        rd_addr_b = 5'd19;
        #12;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL rst_a0: got %h want %h", a0, 32'h0); end
        vectors++; if (b0 !== 32'h0) begin miscompares++; $display("FAIL rst_b0: got %h want %h", b0, 32'h0); end
        vectors++; if (a1 !== RV1) begin miscompares++; $display("FAIL rst_a1: got %h want %h", a1, RV1); end
        vectors++; if (b1 !== RV1) begin miscompares++; $display("FAIL rst_b1: got %h want %h", b1, RV1); end
        rd_addr_a = 5'd0;
        #1;
        vectors++; if (a1 !== 32'h0) begin miscompares++; $display("FAIL rst_zero_a1: got %h want %h", a1, 32'h0); end
        tick();
        reset = 1'b0;
        tick();
        rd_addr_a = 5'd1;
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL post_rst_a0: got %h want %h", a0, 32'h0); end
        vectors++; if (a1 !== RV1) begin miscompares++; $display("FAIL post_rst_a1: got %h want %h", a1, RV1); end
        vectors++; if (b1 !== RV1) begin miscompares++; $display("FAIL post_rst_b1: got %h want %h", b1, RV1); end
    endtask

    task automatic test_write_hold();
        drive_wr(1'b1, 5'd5, 32'd88, 4'hF);
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd5;
        #1;
        vectors++; if (a0 !== 32'd88) begin miscompares++; $display("FAIL hold_byp_a0: got %h want %h", a0, 32'd88); end
        vectors++; if (a1 !== RV1) begin miscompares++; $display("FAIL hold_nobyp_a1: got %h want %h", a1, RV1); end
        tick();
        drive_wr(1'b0, 5'd5, 32'd89, 4'hF);
        #1;
        vectors++; if (a1 !== 32'd88) begin miscompares++; $display("FAIL hold_a1: got %h want %h", a1, 32'd88); end
        vectors++; if (b0 !== 32'd88) begin miscompares++; $display("FAIL hold_b0: got %h want %h", b0, 32'd88); end
        tick();
        vectors++; if (a0 !== 32'd88) begin miscompares++; $display("FAIL hold2_a0: got %h want %h", a0, 32'd88); end
        vectors++; if (b1 !== 32'd88) begin miscompares++; $display("FAIL hold2_b1: got %h want %h", b1, 32'd88); end
    endtask

    task automatic test_byte_enable();
        drive_wr(1'b1, 5'd7, 32'h1122_3344, 4'hF);
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd7;
        tick();
        drive_wr(1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101);
        #1;
        vectors++; if (a0 !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be_byp_a0: got %h want %h", a0, 32'h11BB_33DD); end
        vectors++; if (b0 !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be_byp_b0: got %h want %h", b0, 32'h11BB_33DD); end
        vectors++; if (a1 !== 32'h1122_3344) begin miscompares++; $display("FAIL be_old_a1: got %h want %h", a1, 32'h1122_3344); end
        tick();
        drive_wr(1'b1, 5'd7, 32'hFFFF_FFFF, 4'h0);
        #1;
        vectors++; if (a0 !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be_zero_byp_a0: got %h want %h", a0, 32'h11BB_33DD); end
        vectors++; if (a1 !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be_a1: got %h want %h", a1, 32'h11BB_33DD); end
        tick();
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        vectors++; if (a0 !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be_noop_a0: got %h want %h", a0, 32'h11BB_33DD); end
        vectors++; if (b1 !== 32'h11BB_33DD) begin miscompares++; $display("FAIL be_noop_b1: got %h want %h", b1, 32'h11BB_33DD); end
    endtask

    task automatic test_bypass();
        drive_wr(1'b1, 5'd3, 32'h0000_00FF, 4'hF);
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd3;
        #1;
        vectors++; if (a0 !== 32'h0000_00FF) begin miscompares++; $display("FAIL byp_a0: got %h want %h", a0, 32'h0000_00FF); end
        vectors++; if (b0 !== 32'h0000_00FF) begin miscompares++; $display("FAIL byp_b0: got %h want %h", b0, 32'h0000_00FF); end
        vectors++; if (a1 !== RV1) begin miscompares++; $display("FAIL nobyp_a1: got %h want %h", a1, RV1); end
        tick();
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        vectors++; if (a1 !== 32'h0000_00FF) begin miscompares++; $display("FAIL nobyp_after_a1: got %h want %h", a1, 32'h0000_00FF); end
    endtask

    task automatic test_zero_oor();
        drive_wr(1'b1, 5'd0, 32'd55, 4'hF);
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd1;
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL zero_byp_a0: got %h want %h", a0, 32'h0); end
        tick();
        drive_wr(1'b1, 5'd20, 32'd55, 4'hF);
        rd_addr_a = 5'd20;
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL oor_byp_a0: got %h want %h", a0, 32'h0); end
        tick();
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        rd_addr_a = 5'd0;
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL zero_a0: got %h want %h", a0, 32'h0); end
        vectors++; if (a1 !== 32'h0) begin miscompares++; $display("FAIL zero_a1: got %h want %h", a1, 32'h0); end
        vectors++; if (b0 !== 32'h0) begin miscompares++; $display("FAIL untouched_b0: got %h want %h", b0, 32'h0); end
        vectors++; if (b1 !== RV1) begin miscompares++; $display("FAIL untouched_b1: got %h want %h", b1, RV1); end
        rd_addr_a = 5'd20;
        rd_addr_b = 5'd19;
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL oor_a0: got %h want %h", a0, 32'h0); end
        vectors++; if (a1 !== 32'h0) begin miscompares++; $display("FAIL oor_a1: got %h want %h", a1, 32'h0); end
        vectors++; if (b1 !== RV1) begin miscompares++; $display("FAIL last_b1: got %h want %h", b1, RV1); end
        rd_addr_a = 5'd31;
        rd_addr_b = 5'd5;
        #1;
        vectors++; if (a1 !== 32'h0) begin miscompares++; $display("FAIL oor31_a1: got %h want %h", a1, 32'h0); end
        vectors++; if (b0 !== 32'd88) begin miscompares++; $display("FAIL keep5_b0: got %h want %h", b0, 32'd88); end
    endtask

    task automatic test_clear();
        drive_wr(1'b1, 5'd9, 32'd77, 4'hF);
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd5;
        tick();
        clear = 1'b1;
        drive_wr(1'b1, 5'd9, 32'd66, 4'hF);
        #1;
        vectors++; if (a0 !== 32'd77) begin miscompares++; $display("FAIL clr_nobyp_a0: got %h want %h", a0, 32'd77); end
        tick();
        clear = 1'b0;
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL clr_a0: got %h want %h", a0, 32'h0); end
        vectors++; if (a1 !== RV1) begin miscompares++; $display("FAIL clr_a1: got %h want %h", a1, RV1); end
        vectors++; if (b0 !== 32'h0) begin miscompares++; $display("FAIL clr5_b0: got %h want %h", b0, 32'h0); end
        vectors++; if (b1 !== RV1) begin miscompares++; $display("FAIL clr5_b1: got %h want %h", b1, RV1); end
    endtask

    task automatic test_async_reset();
        drive_wr(1'b1, 5'd2, 32'd12, 4'hF);
        rd_addr_a = 5'd2;
        rd_addr_b = 5'd0;
        tick();
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        vectors++; if (a1 !== 32'd12) begin miscompares++; $display("FAIL pre_rst_a1: got %h want %h", a1, 32'd12); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL async_a0: got %h want %h", a0, 32'h0); end
        vectors++; if (a1 !== RV1) begin miscompares++; $display("FAIL async_a1: got %h want %h", a1, RV1); end
        vectors++; if (b1 !== 32'h0) begin miscompares++; $display("FAIL async_zero_b1: got %h want %h", b1, 32'h0); end
        tick();
        reset = 1'b0;
        drive_wr(1'b1, 5'd2, 32'd99, 4'hF);
        tick();
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        vectors++; if (a1 !== 32'd99) begin miscompares++; $display("FAIL rewrite_a1: got %h want %h", a1, 32'd99); end
        // Reset asserted during a write cycle drops that write.
        drive_wr(1'b1, 5'd2, 32'd44, 4'hF);
        reset = 1'b1;
        #1;
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL rst_wr_byp_a0: got %h want %h", a0, 32'h0); end
        tick();
        reset = 1'b0;
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        tick();
        vectors++; if (a0 !== 32'h0) begin miscompares++; $display("FAIL rst_wr_a0: got %h want %h", a0, 32'h0); end
        vectors++; if (a1 !== RV1) begin miscompares++; $display("FAIL rst_wr_a1: got %h want %h", a1, RV1); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        clear       = 1'b0;
        drive_wr(1'b0, 5'd0, 32'h0, 4'h0);
        rd_addr_a   = 5'd0;
        rd_addr_b   = 5'd0;

        test_reset();
        test_write_hold();
        test_byte_enable();
        test_bypass();
        test_zero_oor();
        test_clear();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
